// File: rtl/mem_arbiter_pkg.sv
// Shared bus command encodings, tag width and owner-table entry type for the
// dcache/icache memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    localparam logic OWNER_DCACHE = 1'b0;
    localparam logic OWNER_ICACHE = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
    } MEM_OWNER_ENTRY;

endpackage

// File: rtl/mem_tag_owner_table.sv
// Registered table recording which requester owns each outstanding load tag,
// with per-owner popcounts of the valid entries.
module mem_tag_owner_table
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_TAGS = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 alloc_en,
    input  logic [TAG_W-1:0]     alloc_tag,
    input  logic                 alloc_owner,
    input  logic                 clear_en,
    input  logic [TAG_W-1:0]     clear_tag,
    input  logic [TAG_W-1:0]     ret_tag,
    output MEM_OWNER_ENTRY       ret_entry,
    output MEM_OWNER_ENTRY       alloc_entry,
    output logic [4:0]           dc_count,
    output logic [4:0]           ic_count
);

    MEM_OWNER_ENTRY table_q [NUM_TAGS];
    MEM_OWNER_ENTRY table_d [NUM_TAGS];
    logic [4:0]     dc_count_q, dc_count_d;
    logic [4:0]     ic_count_q, ic_count_d;

    always_comb begin
        ret_entry   = table_q[ret_tag];
        alloc_entry = table_q[alloc_tag];
    end

    // Allocation is applied after the clear so a same-cycle reuse keeps the entry.
    always_comb begin
        table_d = table_q;
        if (clear_en && clear_tag != '0) begin
            table_d[clear_tag] = '0;
        end
        if (alloc_en && alloc_tag != '0) begin
            table_d[alloc_tag] = '{valid: 1'b1, owner: alloc_owner};
        end
    end

    always_comb begin
        dc_count_d = '0;
        ic_count_d = '0;
        for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            if (table_d[i[TAG_W-1:0]].valid) begin
                if (table_d[i[TAG_W-1:0]].owner == OWNER_ICACHE) begin
                    ic_count_d = ic_count_d + 5'd1;
                end else begin
                    dc_count_d = dc_count_d + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_TAGS; i++) begin
                table_q[i[TAG_W-1:0]] <= '0;
            end
            dc_count_q <= '0;
            ic_count_q <= '0;
        end else begin
            table_q    <= table_d;
            dc_count_q <= dc_count_d;
            ic_count_q <= ic_count_d;
        end
    end

    assign dc_count = dc_count_q;
    assign ic_count = ic_count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates dcache/icache onto the single memory bus and steers returned tags
// to their owner. Optional icache starvation guard: ARB_STARVE_GUARD_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_TAGS = 16
`ifdef ARB_STARVE_GUARD_EN
    , parameter int unsigned STARVE_LIMIT = 4
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        dcache2ctlr_command,
    input  logic [XLEN-1:0]   dcache2ctlr_addr,
    input  logic [63:0]       dcache2ctlr_data,
    output logic [TAG_W-1:0]  Ctlr2proc_response,
    output logic [63:0]       Ctlr2proc_data,
    output logic [TAG_W-1:0]  Ctlr2proc_tag,
    input  logic [1:0]        icache2ctlr_command,
    input  logic [XLEN-1:0]   icache2ctlr_addr,
    output logic [TAG_W-1:0]  ctlr2icache_response,
    output logic [63:0]       ctlr2icache_data,
    output logic [TAG_W-1:0]  ctlr2icache_tag,
    output logic [1:0]        proc2mem_command,
    output logic [XLEN-1:0]   proc2mem_addr,
    output logic [63:0]       proc2mem_data,
    input  logic [TAG_W-1:0]  mem2proc_response,
    input  logic [63:0]       mem2proc_data,
    input  logic [TAG_W-1:0]  mem2proc_tag,
    output logic [4:0]        dc_outstanding,
    output logic [4:0]        ic_outstanding,
    output logic              tag_error
);

    logic           dc_req, ic_req, ic_forced;
    logic           grant_dc, grant_ic;
    logic           alloc_en, ret_valid, alloc_conflict;
    logic           tag_error_q, tag_error_d;
    MEM_OWNER_ENTRY ret_entry, alloc_entry;

`ifdef ARB_STARVE_GUARD_EN
    logic [2:0] starve_q, starve_d;

    always_comb begin
        ic_forced = ic_req && ({29'b0, starve_q} >= STARVE_LIMIT);
        starve_d  = starve_q;
        if (grant_ic) begin
            starve_d = '0;
        end else if (ic_req && starve_q != '1) begin
            starve_d = starve_q + 3'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) starve_q <= '0;
        else       starve_q <= starve_d;
    end
`else
    always_comb ic_forced = 1'b0;
`endif

    always_comb begin
        dc_req   = dcache2ctlr_command != BUS_NONE;
        ic_req   = icache2ctlr_command != BUS_NONE;
        grant_dc = dc_req && !ic_forced;
        grant_ic = ic_req && !grant_dc;

        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (grant_dc) begin
            proc2mem_command = dcache2ctlr_command;
            proc2mem_addr    = dcache2ctlr_addr;
            proc2mem_data    = dcache2ctlr_data;
        end else if (grant_ic) begin
            proc2mem_command = icache2ctlr_command;
            proc2mem_addr    = icache2ctlr_addr;
        end

        Ctlr2proc_response   = grant_dc ? mem2proc_response : '0;
        ctlr2icache_response = grant_ic ? mem2proc_response : '0;

        // The table is treated as empty while reset is held.
        ret_valid       = (mem2proc_tag != '0) && ret_entry.valid && !reset;
        Ctlr2proc_tag   = (ret_valid && ret_entry.owner == OWNER_DCACHE) ? mem2proc_tag : '0;
        ctlr2icache_tag = (ret_valid && ret_entry.owner == OWNER_ICACHE) ? mem2proc_tag : '0;
        Ctlr2proc_data   = mem2proc_data;
        ctlr2icache_data = mem2proc_data;

        alloc_en = ((grant_dc && dcache2ctlr_command == BUS_LOAD) ||
                    (grant_ic && icache2ctlr_command == BUS_LOAD)) &&
                   (mem2proc_response != '0);
        alloc_conflict = alloc_en && alloc_entry.valid &&
                         !(ret_valid && mem2proc_tag == mem2proc_response);
        tag_error_d = tag_error_q || alloc_conflict ||
                      ((mem2proc_tag != '0) && !ret_valid);
    end

    always_ff @(posedge clock) begin
        if (reset) tag_error_q <= 1'b0;
        else       tag_error_q <= tag_error_d;
    end

    assign tag_error = tag_error_q;

    mem_tag_owner_table #(
        .NUM_TAGS (NUM_TAGS)
    ) u_owner_table (
        .clock       (clock),
        .reset       (reset),
        .alloc_en    (alloc_en),
        .alloc_tag   (mem2proc_response),
        .alloc_owner (grant_ic),
        .clear_en    (ret_valid),
        .clear_tag   (mem2proc_tag),
        .ret_tag     (mem2proc_tag),
        .ret_entry   (ret_entry),
        .alloc_entry (alloc_entry),
        .dc_count    (dc_outstanding),
        .ic_count    (ic_outstanding)
    );

endmodule
